// File: rtl/vgroup_pkg.sv
// Shared definitions for the vector-group issue/retire path: LMUL encodings,
// the LMUL decode used by both the grouping selector and the retire tracker,
// and the retire tracker state type.
package vgroup_pkg;

    localparam logic [2:0] LMUL_1 = 3'b000;
    localparam logic [2:0] LMUL_2 = 3'b001;
    localparam logic [2:0] LMUL_4 = 3'b010;
    localparam logic [2:0] LMUL_8 = 3'b011;

    localparam int VREG_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    // Encodings with the top bit set are reserved and map to the caller's
    // configured maximum group size.
    function automatic logic [3:0] lmul_decode(input logic [2:0] enc,
                                               input logic [3:0] reserved_total);
        logic [3:0] total;
        case (enc)
            LMUL_1:  total = 4'd1;
            LMUL_2:  total = 4'd2;
            LMUL_4:  total = 4'd4;
            LMUL_8:  total = 4'd8;
            default: total = reserved_total;
        endcase
        return total;
    endfunction

endpackage

// File: rtl/vgroup_mask_gen.sv
// Builds the set of registers covered by a group: total consecutive registers
// starting at base, wrapping around the top of the register file.
module vgroup_mask_gen
    import vgroup_pkg::*;
#(
    parameter int NUM_VREGS = 32
) (
    input  logic [VREG_ADDR_W-1:0] base_i,
    input  logic [3:0]             total_i,
    output logic [NUM_VREGS-1:0]   mask_o
);

    // A register is covered when its wrapped distance from base is below total.
    always_comb begin
        logic [VREG_ADDR_W-1:0] offset;
        mask_o = '0;
        offset = '0;
        for (int i = 0; i < NUM_VREGS; i++) begin
            offset = VREG_ADDR_W'(i) - base_i;
            if ({1'b0, offset} < {{(VREG_ADDR_W-3){1'b0}}, total_i}) begin
                mask_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vgroup_retire_tracker.sv
// Retire tracker for grouped vector instructions: records the group at issue,
// marks its destinations busy, retires in-order writebacks, pulses group_done
// on the last one and offers a busy-register hazard check for the next op.
module vgroup_retire_tracker
    import vgroup_pkg::*;
#(
    parameter int NUM_VREGS = 32,
    parameter int MAX_LMUL  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4:0]             start_rdest,
    input  logic [2:0]             start_lmul,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   flush,
    input  logic [4:0]             chk_raA,
    input  logic [4:0]             chk_raB,
    input  logic [4:0]             chk_rdest,
    output logic                   hazard,
    output logic [NUM_VREGS-1:0]   busy_mask,
    output logic [3:0]             remaining,
    output logic                   group_active,
    output logic                   group_done,
    output logic                   err
);

    localparam logic [3:0] RESERVED_TOTAL = 4'(MAX_LMUL);

    state_e                 state_q, state_d;
    logic [NUM_VREGS-1:0]   busy_q, busy_d;
    logic [3:0]             remaining_q, remaining_d;
    logic [4:0]             expected_q, expected_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [3:0]             start_total;
    logic [NUM_VREGS-1:0]   start_mask;

    assign start_total = lmul_decode(start_lmul, RESERVED_TOTAL);

    vgroup_mask_gen #(
        .NUM_VREGS (NUM_VREGS)
    ) u_mask_gen (
        .base_i  (start_rdest),
        .total_i (start_total),
        .mask_o  (start_mask)
    );

    // Next-state logic: flush overrides everything, protocol errors only set err.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        remaining_d = remaining_q;
        expected_d  = expected_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (flush) begin
            state_d     = IDLE;
            busy_d      = '0;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_valid) begin
                        err_d = 1'b1;
                    end
                    if (start_valid) begin
                        state_d     = COLLECT;
                        busy_d      = start_mask;
                        remaining_d = start_total;
                        expected_d  = start_rdest;
                    end
                end
                COLLECT: begin
                    if (wb_valid) begin
                        if (wb_rd == expected_q) begin
                            busy_d[wb_rd] = 1'b0;
                            expected_d    = expected_q + 5'd1;
                            remaining_d   = remaining_q - 4'd1;
                            if (remaining_q == 4'd1) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            remaining_q <= '0;
            expected_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
            expected_q  <= expected_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign group_active = (state_q == COLLECT);
    assign group_done   = done_q;
    assign err          = err_q;
    assign remaining    = remaining_q;
    assign busy_mask    = busy_q;
    assign hazard       = busy_q[chk_raA] | busy_q[chk_raB] | busy_q[chk_rdest];

endmodule

// File: tb/tb_vgroup_retire_tracker.sv
// Self-checking bench for vgroup_retire_tracker: a hand-computed vector table
// for the directed corner cases, then randomized traffic against a queue model.
module tb_vgroup_retire_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [4:0]  start_rdest;
    logic [2:0]  start_lmul;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [4:0]  chk_raA;
    logic [4:0]  chk_raB;
    logic [4:0]  chk_rdest;
    logic        hazard;
    logic [31:0] busy_mask;
    logic [3:0]  remaining;
    logic        group_active;
    logic        group_done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    vgroup_retire_tracker #(
        .NUM_VREGS (32),
        .MAX_LMUL  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_rdest  (start_rdest),
        .start_lmul   (start_lmul),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .chk_raA      (chk_raA),
        .chk_raB      (chk_raB),
        .chk_rdest    (chk_rdest),
        .hazard       (hazard),
        .busy_mask    (busy_mask),
        .remaining    (remaining),
        .group_active (group_active),
        .group_done   (group_done),
        .err          (err)
    );

    typedef struct {
        logic        rst;
        logic        sv;
        logic [4:0]  rd;
        logic [2:0]  lm;
        logic        wv;
        logic [4:0]  wr;
        logic        fl;
        logic [4:0]  ca;
        logic [4:0]  cb;
        logic [4:0]  cd;
        logic [31:0] busy;
        logic [3:0]  rem;
        logic        act;
        logic        done;
        logic        err;
        logic        haz;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the outstanding group is an ordered list of registers.
    int pending[$];
    bit mActive = 0;
    bit mDone = 0;
    bit mErr = 0;

    function automatic logic [31:0] modelBusy();
        logic [31:0] m;
        m = '0;
        foreach (pending[k]) m[pending[k]] = 1'b1;
        return m;
    endfunction

    function automatic int groupSize(input logic [2:0] lm);
        return (lm < 3'd4) ? (1 << lm) : 8;
    endfunction

    task automatic modelStep(input logic rst, input logic sv, input logic [4:0] rd,
                             input logic [2:0] lm, input logic wv, input logic [4:0] wr,
                             input logic fl);
        if (rst) begin
            pending.delete();
            mActive = 0;
            mDone = 0;
            mErr = 0;
        end else if (fl) begin
            pending.delete();
            mActive = 0;
            mDone = 0;
        end else if (!mActive) begin
            mDone = 0;
            if (wv) mErr = 1;
            if (sv) begin
                for (int k = 0; k < groupSize(lm); k++) pending.push_back((int'(rd) + k) % 32);
                mActive = 1;
            end
        end else begin
            mDone = 0;
            if (wv) begin
                if (int'(wr) == pending[0]) begin
                    void'(pending.pop_front());
                    if (pending.size() == 0) begin
                        mActive = 0;
                        mDone = 1;
                    end
                end else begin
                    mErr = 1;
                end
            end
        end
    endtask

    task automatic addV(input logic rst, input logic sv, input logic [4:0] rd, input logic [2:0] lm,
                        input logic wv, input logic [4:0] wr, input logic fl,
                        input logic [4:0] ca, input logic [4:0] cb, input logic [4:0] cd,
                        input logic [31:0] busy, input logic [3:0] rem, input logic act,
                        input logic done, input logic e, input logic haz);
        vec_t v;
        v.rst = rst; v.sv = sv; v.rd = rd; v.lm = lm; v.wv = wv; v.wr = wr; v.fl = fl;
        v.ca = ca; v.cb = cb; v.cd = cd;
        v.busy = busy; v.rem = rem; v.act = act; v.done = done; v.err = e; v.haz = haz;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic applyStimulus(input logic rst, input logic sv, input logic [4:0] rd,
                                 input logic [2:0] lm, input logic wv, input logic [4:0] wr,
                                 input logic fl, input logic [4:0] ca, input logic [4:0] cb,
                                 input logic [4:0] cd);
        @(negedge clk);
        reset = rst; start_valid = sv; start_rdest = rd; start_lmul = lm;
        wb_valid = wv; wb_rd = wr; flush = fl;
        chk_raA = ca; chk_raB = cb; chk_rdest = cd;
        @(posedge clk);
        modelStep(rst, sv, rd, lm, wv, wr, fl);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] eBusy, input logic [3:0] eRem,
                               input logic eAct, input logic eDone, input logic eErr,
                               input logic eHaz);
        bit bad;
        vectors++;
        bad = (busy_mask !== eBusy) || (remaining !== eRem) || (group_active !== eAct) ||
              (start_ready !== !eAct) || (group_done !== eDone) || (err !== eErr) ||
              (hazard !== eHaz);
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got busy=%h rem=%0d act=%b rdy=%b done=%b err=%b haz=%b, expected busy=%h rem=%0d act=%b rdy=%b done=%b err=%b haz=%b",
                     name, busy_mask, remaining, group_active, start_ready, group_done, err, hazard,
                     eBusy, eRem, eAct, !eAct, eDone, eErr, eHaz);
        end
    endtask

    initial begin
        reset = 1'b1; start_valid = 0; start_rdest = 0; start_lmul = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; chk_raA = 31; chk_raB = 31; chk_rdest = 31;

        //     rst sv rd  lm  wv wr  fl ca  cb  cd   busy          rem act dn er hz
        addV(1, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 1, 4,  1, 0, 0,  0, 5,  31, 31, 32'h00000030, 2, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 4,  0, 4,  31, 31, 32'h00000020, 1, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 5,  0, 31, 31, 31, 32'h00000000, 0, 0, 1, 0, 0);
        addV(0, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 1, 30, 2, 0, 0,  0, 31, 0,  31, 32'hC0000003, 4, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 30, 0, 31, 31, 31, 32'h80000003, 3, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 31, 0, 31, 31, 31, 32'h00000003, 2, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 0,  0, 1,  31, 31, 32'h00000002, 1, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 1,  0, 31, 31, 31, 32'h00000000, 0, 0, 1, 0, 0);
        addV(0, 1, 8,  3, 0, 0,  0, 31, 31, 31, 32'h0000FF00, 8, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 9,  0, 31, 31, 31, 32'h0000FF00, 8, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 8,  0, 31, 31, 31, 32'h0000FE00, 7, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 9,  0, 31, 31, 31, 32'h0000FC00, 6, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 10, 0, 31, 31, 31, 32'h0000F800, 5, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 11, 0, 31, 31, 31, 32'h0000F000, 4, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 12, 0, 31, 31, 31, 32'h0000E000, 3, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 13, 0, 31, 31, 31, 32'h0000C000, 2, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 14, 0, 31, 31, 31, 32'h00008000, 1, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 15, 0, 31, 31, 31, 32'h00000000, 0, 0, 1, 1, 0);
        addV(0, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 1, 0);
        addV(1, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 1, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000001, 1, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 1, 0, 0);
        addV(0, 1, 2,  0, 0, 0,  0, 2,  31, 31, 32'h00000004, 1, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 2,  0, 2,  31, 31, 32'h00000000, 0, 0, 1, 0, 0);
        addV(0, 1, 16, 4, 0, 0,  0, 31, 31, 23, 32'h00FF0000, 8, 1, 0, 0, 1);
        addV(0, 0, 0,  0, 1, 16, 0, 31, 31, 31, 32'h00FE0000, 7, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 17, 0, 31, 31, 31, 32'h00FC0000, 6, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 18, 0, 31, 31, 31, 32'h00F80000, 5, 1, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 19, 1, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 0, 0,  0, 1, 3,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 1, 0);
        addV(0, 1, 20, 5, 0, 0,  0, 31, 31, 31, 32'h0FF00000, 8, 1, 0, 1, 0);
        addV(0, 0, 0,  0, 1, 20, 0, 20, 31, 31, 32'h0FE00000, 7, 1, 0, 1, 0);
        addV(1, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 1, 28, 7, 0, 0,  0, 31, 31, 31, 32'hF000000F, 8, 1, 0, 0, 1);
        addV(0, 1, 3,  0, 0, 0,  1, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);
        addV(0, 1, 5,  0, 1, 5,  0, 31, 31, 31, 32'h00000020, 1, 1, 0, 1, 0);
        addV(1, 0, 0,  0, 0, 0,  0, 31, 31, 31, 32'h00000000, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].sv, vecs[i].rd, vecs[i].lm, vecs[i].wv,
                          vecs[i].wr, vecs[i].fl, vecs[i].ca, vecs[i].cb, vecs[i].cd);
            checkOutput($sformatf("table[%0d]", i), vecs[i].busy, vecs[i].rem, vecs[i].act,
                        vecs[i].done, vecs[i].err, vecs[i].haz);
        end

        // Randomized traffic, writebacks mostly in the expected order.
        for (int n = 0; n < 3000; n++) begin
            logic       rst, sv, wv, fl;
            logic [4:0] rd, wr, ca, cb, cd;
            logic [2:0] lm;
            logic [31:0] mb;
            rst = ($urandom_range(0, 99) < 2);
            fl  = ($urandom_range(0, 99) < 3);
            sv  = ($urandom_range(0, 99) < 40);
            wv  = ($urandom_range(0, 99) < 60);
            rd  = 5'($urandom_range(0, 31));
            lm  = 3'($urandom_range(0, 7));
            if (pending.size() > 0 && $urandom_range(0, 99) < 85) wr = 5'(pending[0]);
            else wr = 5'($urandom_range(0, 31));
            ca = 5'($urandom_range(0, 31));
            cb = 5'($urandom_range(0, 31));
            cd = 5'($urandom_range(0, 31));
            applyStimulus(rst, sv, rd, lm, wv, wr, fl, ca, cb, cd);
            mb = modelBusy();
            checkOutput($sformatf("random[%0d]", n), mb, 4'(pending.size()), mActive, mDone,
                        mErr, mb[ca] | mb[cb] | mb[cd]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
